// File: rtl/ex_mem_pkg.sv
// Shared widths, reset constants and stall bit indices for the EX/MEM pipeline register.
// The EX-stage payload is bundled as one struct so bubble/hold apply to all fields at once.
package ex_mem_pkg;

    localparam int unsigned RegBus       = 32;
    localparam int unsigned RegAddrBus   = 5;
    localparam int unsigned AluOpBus     = 8;
    localparam int unsigned DoubleRegBus = 64;

    localparam logic                  RstEnable    = 1'b1;
    localparam logic                  WriteDisable = 1'b0;
    localparam logic [RegBus-1:0]     ZeroWord     = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
    localparam logic [AluOpBus-1:0]   EXE_NOP_OP   = 8'b0000_0000;

    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;

    typedef struct packed {
        logic                  we;
        logic [RegAddrBus-1:0] w_reg_addr;
        logic [RegBus-1:0]     wdata;
        logic                  whilo;
        logic [RegBus-1:0]     hi;
        logic [RegBus-1:0]     lo;
        logic [AluOpBus-1:0]   aluop;
        logic [RegBus-1:0]     mem_addr;
        logic [RegBus-1:0]     reg2;
    } mem_stage_t;

    function automatic mem_stage_t mem_bubble();
        mem_stage_t b;
        b.we         = WriteDisable;
        b.w_reg_addr = NOPRegAddr;
        b.wdata      = ZeroWord;
        b.whilo      = 1'b0;
        b.hi         = ZeroWord;
        b.lo         = ZeroWord;
        b.aluop      = EXE_NOP_OP;
        b.mem_addr   = ZeroWord;
        b.reg2       = ZeroWord;
        return b;
    endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with stall/flush handling.
// Define MADD_TEMP_EN to add the madd/msub partial-product and step-counter feedback to EX.
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic                    flush,
    input  logic                    ex_we_i,
    input  logic [RegAddrBus-1:0]   ex_w_reg_addr_i,
    input  logic [RegBus-1:0]       ex_wdata_i,
    input  logic                    ex_whilo_i,
    input  logic [RegBus-1:0]       ex_hi_i,
    input  logic [RegBus-1:0]       ex_lo_i,
    input  logic [AluOpBus-1:0]     ex_aluop_i,
    input  logic [RegBus-1:0]       ex_mem_addr_i,
    input  logic [RegBus-1:0]       ex_reg2_i,
`ifdef MADD_TEMP_EN
    input  logic [DoubleRegBus-1:0] ex_hilo_temp_i,
    input  logic [1:0]              ex_cnt_i,
    output logic [DoubleRegBus-1:0] hilo_temp_o,
    output logic [1:0]              cnt_o,
`endif
    output logic                    mem_we_o,
    output logic [RegAddrBus-1:0]   mem_w_reg_addr_o,
    output logic [RegBus-1:0]       mem_wdata_o,
    output logic                    mem_whilo_o,
    output logic [RegBus-1:0]       mem_hi_o,
    output logic [RegBus-1:0]       mem_lo_o,
    output logic [AluOpBus-1:0]     mem_aluop_o,
    output logic [RegBus-1:0]       mem_mem_addr_o,
    output logic [RegBus-1:0]       mem_reg2_o
);

    mem_stage_t ex_fields;
    mem_stage_t mem_q;

    // Only the EX and MEM stall bits matter to this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    assign ex_fields.we         = ex_we_i;
    assign ex_fields.w_reg_addr = ex_w_reg_addr_i;
    assign ex_fields.wdata      = ex_wdata_i;
    assign ex_fields.whilo      = ex_whilo_i;
    assign ex_fields.hi         = ex_hi_i;
    assign ex_fields.lo         = ex_lo_i;
    assign ex_fields.aluop      = ex_aluop_i;
    assign ex_fields.mem_addr   = ex_mem_addr_i;
    assign ex_fields.reg2       = ex_reg2_i;

`ifdef MADD_TEMP_EN
    logic [DoubleRegBus-1:0] hilo_temp_q;
    logic [1:0]              cnt_q;
`endif

    // Priority: reset, flush, bubble (EX stalled, MEM running), advance; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush) begin
            mem_q       <= mem_bubble();
`ifdef MADD_TEMP_EN
            hilo_temp_q <= '0;
            cnt_q       <= '0;
`endif
        end else if (stall[STALL_EX] && !stall[STALL_MEM]) begin
            mem_q       <= mem_bubble();
`ifdef MADD_TEMP_EN
            hilo_temp_q <= ex_hilo_temp_i;
            cnt_q       <= ex_cnt_i;
`endif
        end else if (!stall[STALL_EX]) begin
            mem_q       <= ex_fields;
`ifdef MADD_TEMP_EN
            hilo_temp_q <= '0;
            cnt_q       <= '0;
`endif
        end
    end

`ifdef MADD_TEMP_EN
    assign hilo_temp_o = hilo_temp_q;
    assign cnt_o       = cnt_q;
`endif

    assign mem_we_o         = mem_q.we;
    assign mem_w_reg_addr_o = mem_q.w_reg_addr;
    assign mem_wdata_o      = mem_q.wdata;
    assign mem_whilo_o      = mem_q.whilo;
    assign mem_hi_o         = mem_q.hi;
    assign mem_lo_o         = mem_q.lo;
    assign mem_aluop_o      = mem_q.aluop;
    assign mem_mem_addr_o   = mem_q.mem_addr;
    assign mem_reg2_o       = mem_q.reg2;

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: vector table plus scoreboard queue, then a random hold run.
// Works with or without MADD_TEMP_EN; the temp/counter checks exist only when it is defined.
module tb_ex_mem;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [63:0] temp;
        logic [1:0]  cnt;
    } fields_t;

    typedef struct {
        string     name;
        logic      rst;
        logic      flush;
        logic [5:0] stall;
        fields_t   in;
        fields_t   exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        ex_we_i;
    logic [4:0]  ex_w_reg_addr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_whilo_i;
    logic [31:0] ex_hi_i;
    logic [31:0] ex_lo_i;
    logic [7:0]  ex_aluop_i;
    logic [31:0] ex_mem_addr_i;
    logic [31:0] ex_reg2_i;
    logic        mem_we_o;
    logic [4:0]  mem_w_reg_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_whilo_o;
    logic [31:0] mem_hi_o;
    logic [31:0] mem_lo_o;
    logic [7:0]  mem_aluop_o;
    logic [31:0] mem_mem_addr_o;
    logic [31:0] mem_reg2_o;
`ifdef MADD_TEMP_EN
    logic [63:0] ex_hilo_temp_i;
    logic [1:0]  ex_cnt_i;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;
`endif

    int      errors = 0;
    int      checks = 0;
    fields_t exp_q[$];
    vec_t    vecs[$];

    always #5 clk = ~clk;

    ex_mem dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .ex_we_i          (ex_we_i),
        .ex_w_reg_addr_i  (ex_w_reg_addr_i),
        .ex_wdata_i       (ex_wdata_i),
        .ex_whilo_i       (ex_whilo_i),
        .ex_hi_i          (ex_hi_i),
        .ex_lo_i          (ex_lo_i),
        .ex_aluop_i       (ex_aluop_i),
        .ex_mem_addr_i    (ex_mem_addr_i),
        .ex_reg2_i        (ex_reg2_i),
`ifdef MADD_TEMP_EN
        .ex_hilo_temp_i   (ex_hilo_temp_i),
        .ex_cnt_i         (ex_cnt_i),
        .hilo_temp_o      (hilo_temp_o),
        .cnt_o            (cnt_o),
`endif
        .mem_we_o         (mem_we_o),
        .mem_w_reg_addr_o (mem_w_reg_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_whilo_o      (mem_whilo_o),
        .mem_hi_o         (mem_hi_o),
        .mem_lo_o         (mem_lo_o),
        .mem_aluop_o      (mem_aluop_o),
        .mem_mem_addr_o   (mem_mem_addr_o),
        .mem_reg2_o       (mem_reg2_o)
    );

    // The controller never lets EX advance into a stalled MEM.
    always @(posedge clk) begin
        assert (!(stall[3] == 1'b0 && stall[4] == 1'b1))
            else $error("illegal stall vector %b", stall);
    end

    function automatic fields_t mk(logic we, logic [4:0] waddr, logic [31:0] wdata,
                                   logic whilo, logic [31:0] hi, logic [31:0] lo,
                                   logic [7:0] aluop, logic [31:0] addr, logic [31:0] reg2,
                                   logic [63:0] temp, logic [1:0] cnt);
        fields_t f;
        f.we = we; f.waddr = waddr; f.wdata = wdata; f.whilo = whilo;
        f.hi = hi; f.lo = lo; f.aluop = aluop; f.addr = addr; f.reg2 = reg2;
        f.temp = temp; f.cnt = cnt;
        return f;
    endfunction

    // Expected value after an advance: payload passes, temp state clears.
    function automatic fields_t passed(fields_t f);
        fields_t r = f;
        r.temp = '0;
        r.cnt  = '0;
        return r;
    endfunction

    // Expected value after a bubble: payload zero, temp state captured.
    function automatic fields_t bubbled(fields_t f);
        fields_t r = '0;
        r.temp = f.temp;
        r.cnt  = f.cnt;
        return r;
    endfunction

    function automatic fields_t rnd();
        fields_t f;
        f.we = 1'($urandom); f.waddr = 5'($urandom); f.wdata = $urandom;
        f.whilo = 1'($urandom); f.hi = $urandom; f.lo = $urandom;
        f.aluop = 8'($urandom); f.addr = $urandom; f.reg2 = $urandom;
        f.temp = {$urandom, $urandom}; f.cnt = 2'($urandom);
        return f;
    endfunction

    task automatic drive(fields_t f);
        ex_we_i = f.we; ex_w_reg_addr_i = f.waddr; ex_wdata_i = f.wdata;
        ex_whilo_i = f.whilo; ex_hi_i = f.hi; ex_lo_i = f.lo; ex_aluop_i = f.aluop;
        ex_mem_addr_i = f.addr; ex_reg2_i = f.reg2;
`ifdef MADD_TEMP_EN
        ex_hilo_temp_i = f.temp;
        ex_cnt_i       = f.cnt;
`endif
    endtask

    task automatic check(string name, string field, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h, want %0h", name, field, act, exp);
        end
    endtask

    task automatic compare(string name);
        fields_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.scoreboard: got empty queue, want one entry", name);
            return;
        end
        e = exp_q.pop_front();
        check(name, "we",    64'(mem_we_o),         64'(e.we));
        check(name, "waddr", 64'(mem_w_reg_addr_o), 64'(e.waddr));
        check(name, "wdata", 64'(mem_wdata_o),      64'(e.wdata));
        check(name, "whilo", 64'(mem_whilo_o),      64'(e.whilo));
        check(name, "hi",    64'(mem_hi_o),         64'(e.hi));
        check(name, "lo",    64'(mem_lo_o),         64'(e.lo));
        check(name, "aluop", 64'(mem_aluop_o),      64'(e.aluop));
        check(name, "addr",  64'(mem_mem_addr_o),   64'(e.addr));
        check(name, "reg2",  64'(mem_reg2_o),       64'(e.reg2));
`ifdef MADD_TEMP_EN
        check(name, "temp",  hilo_temp_o,           e.temp);
        check(name, "cnt",   64'(cnt_o),            64'(e.cnt));
`endif
    endtask

    task automatic step(string name, logic r, logic fl, logic [5:0] st, fields_t in,
                        fields_t exp);
        rst = r; flush = fl; stall = st;
        drive(in);
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        compare(name);
    endtask

    task automatic add(string name, logic r, logic fl, logic [5:0] st, fields_t in,
                       fields_t exp);
        vec_t v;
        v.name = name; v.rst = r; v.flush = fl; v.stall = st; v.in = in; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        fields_t z, a, p1, p2, b1, f, m1, m2, g, r;
        z  = '0;
        a  = mk(1, 5'h1f, 32'hFFFF_FFFF, 1, 32'hDEAD_BEEF, 32'hBEEF_DEAD, 8'h7f,
                32'h1000_0004, 32'h5A5A_5A5A, 64'hFFFF_0000_FFFF_0000, 2'd3);
        p1 = mk(1, 5'd3, 32'h1234_5678, 0, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0,
                64'h1111, 2'd2);
        p2 = mk(0, 5'd17, 32'h8000_0001, 1, 32'hA5A5_0000, 32'h0000_5A5A, 8'h23,
                32'h0000_0FFC, 32'hFEDC_BA98, 64'h0, 2'd0);
        b1 = mk(1, 5'd7, 32'h3333, 1, 32'h44, 32'h55, 8'h2b, 32'h40, 32'h66,
                64'hAAAA_0000_0000_5555, 2'd1);
        f  = mk(1, 5'd9, 32'hCAFE_F00D, 0, 32'h0, 32'h0, 8'h20, 32'h100, 32'h77,
                64'h0, 2'd0);
        m1 = mk(0, 5'd0, 32'h0, 1, 32'h0, 32'h0, 8'hA6, 32'h0, 32'h0, 64'h2, 2'd1);
        m2 = mk(0, 5'd0, 32'h0, 1, 32'h1, 32'h2, 8'hA6, 32'h0, 32'h0, 64'h2, 2'd2);
        g  = mk(1, 5'd31, 32'h0F0F_0F0F, 1, 32'h1, 32'h2, 8'h24, 32'hFFFF_FFFC, 32'h1,
                64'h0, 2'd0);

        add("reset0",      1, 0, 6'b000000, a,  z);
        add("reset1",      1, 0, 6'b011111, a,  z);
        add("pass1",       0, 0, 6'b000000, p1, passed(p1));
        add("pass2",       0, 0, 6'b000000, p2, passed(p2));
        add("bubble",      0, 0, 6'b001111, b1, bubbled(b1));
        add("pass_cafe",   0, 0, 6'b000000, f,  f);
        for (int i = 0; i < 3; i++) begin
            add($sformatf("hold%0d", i), 0, 0, 6'b011111,
                mk(1, 5'(10 + i), 32'h0BAD_0000 + i, 1, 32'h9, 32'h8, 8'h11, 32'h4,
                   32'h5, 64'h99, 2'd1), f);
        end
        add("madd1",       0, 0, 6'b001111, m1, bubbled(m1));
        add("madd2",       0, 0, 6'b000000, m2, passed(m2));
        add("pass_g",      0, 0, 6'b000000, g,  g);
        add("hold_g",      0, 0, 6'b011111, a,  g);
        add("flush_hold",  0, 1, 6'b011111, a,  z);
        add("flush_bub",   0, 1, 6'b001111, b1, z);
        add("bub_again",   0, 0, 6'b001111, b1, bubbled(b1));
        add("hold_temp",   0, 0, 6'b011111, a,  bubbled(b1));
        add("rst_madd",    1, 0, 6'b001111, b1, z);
        add("pass_a",      0, 0, 6'b000000, a,  passed(a));
        add("flush_run",   0, 1, 6'b000000, p1, z);

        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].rst, vecs[i].flush, vecs[i].stall, vecs[i].in,
                 vecs[i].exp);
        end

        // Long hold with changing EX inputs, then release.
        r = rnd();
        step("rnd_pass", 0, 0, 6'b000000, r, passed(r));
        for (int i = 0; i < 5; i++) begin
            step($sformatf("rnd_hold%0d", i), 0, 0, 6'b111111, rnd(), passed(r));
        end
        r = rnd();
        step("rnd_release", 0, 0, 6'b000000, r, passed(r));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
